// File: rtl/lcd_wr_ctrl.sv
// rtl/lcd_wr_ctrl.sv - 8080-style LCD write controller: word FIFO feeding a strobe-timing FSM
// Delay words (all-zero input, executed in the NOP state) exist only when LCD_NOP_DELAY_EN is defined.
module lcd_wr_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int NOP_CYC     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic [15:0] lcd_data,
    output logic        busy
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_LH  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_CYC = (NOP_CYC > MAX_LH) ? NOP_CYC : MAX_LH;
    localparam int TW      = $clog2(MAX_CYC) + 1;
`ifdef LCD_NOP_DELAY_EN
    localparam int EW = 18;
`else
    localparam int EW = 17;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE_LO,
        S_STROBE_HI
`ifdef LCD_NOP_DELAY_EN
        , S_NOP
`endif
    } state_t;

    logic [EW-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          word_write;
    logic          word_keep;
    logic [EW-1:0] push_word;
    logic [EW-1:0] head;
    logic          unused_in_bits;

    state_t        state;
    state_t        state_next;
    state_t        head_state;
    logic          in_tail;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_init;
    logic          tmr_load;
    logic          tmr_last;
    logic          cur_rs;
    logic [15:0]   cur_data;
    logic          nxt_cs;
    logic          nxt_wr;
    logic          nxt_rs;
    logic [15:0]   nxt_data;

    assign word_write     = in_data[31] && ((in_data[17:16] == 2'b01) || (in_data[17:16] == 2'b10));
    assign unused_in_bits = ^in_data[30:18];

`ifdef LCD_NOP_DELAY_EN
    // A kept word that is not a write can only be the all-zero delay word.
    assign word_keep  = word_write || (in_data == 32'h0000_0000);
    assign push_word  = {~word_write, in_data[17], in_data[15:0]};
    assign head_state = head[17] ? S_NOP : S_SETUP;
    assign in_tail    = (state == S_STROBE_HI) || (state == S_NOP);
`else
    assign word_keep  = word_write;
    assign push_word  = {in_data[17], in_data[15:0]};
    assign head_state = S_SETUP;
    assign in_tail    = (state == S_STROBE_HI);
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign in_ready   = ~fifo_full;
    assign push       = in_valid && in_ready && word_keep;
    assign head       = mem[rd_ptr];
    assign busy       = !fifo_empty || (state != S_IDLE);
    assign lcd_rd     = 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The tail of a strobe (or delay) doubles as the dispatch slot, so writes chain without idle gaps.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tmr_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tmr_load   = 1'b1;
                    state_next = head_state;
                end
            end
            S_SETUP: begin
                tmr_load   = 1'b1;
                state_next = S_STROBE_LO;
            end
            S_STROBE_LO: begin
                if (tmr_last) begin
                    tmr_load   = 1'b1;
                    state_next = S_STROBE_HI;
                end
            end
            default: begin
                if (!in_tail) begin
                    state_next = S_IDLE;
                end else if (tmr_last) begin
                    tmr_load = 1'b1;
                    if (fifo_empty) begin
                        state_next = S_IDLE;
                    end else begin
                        pop        = 1'b1;
                        state_next = head_state;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (state_next)
            S_STROBE_LO: tmr_init = TW'(WR_LOW_CYC - 1);
            S_STROBE_HI: tmr_init = TW'(WR_HIGH_CYC - 1);
`ifdef LCD_NOP_DELAY_EN
            S_NOP:       tmr_init = TW'(NOP_CYC - 1);
`endif
            default:     tmr_init = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr <= '0;
        end else if (tmr_load) begin
            tmr <= tmr_init;
        end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
        end
    end

    assign tmr_last = (tmr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_rs   <= 1'b1;
            cur_data <= '0;
        end else if (pop) begin
            cur_rs   <= head[16];
            cur_data <= head[15:0];
        end
    end

    always_comb begin
        nxt_cs   = 1'b1;
        nxt_wr   = 1'b1;
        nxt_rs   = 1'b1;
        nxt_data = '0;
        case (state)
            S_SETUP, S_STROBE_HI: begin
                nxt_cs   = 1'b0;
                nxt_rs   = cur_rs;
                nxt_data = cur_data;
            end
            S_STROBE_LO: begin
                nxt_cs   = 1'b0;
                nxt_wr   = 1'b0;
                nxt_rs   = cur_rs;
                nxt_data = cur_data;
            end
            default: begin
                nxt_cs = 1'b1;
            end
        endcase
    end

    // Pins are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_cs   <= 1'b1;
            lcd_wr   <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_data <= '0;
        end else begin
            lcd_cs   <= nxt_cs;
            lcd_wr   <= nxt_wr;
            lcd_rs   <= nxt_rs;
            lcd_data <= nxt_data;
        end
    end
endmodule

// File: tb/tb_lcd_wr_ctrl.sv
// tb/tb_lcd_wr_ctrl.sv - self-checking bench for lcd_wr_ctrl against a queue-of-writes reference model
module tb_lcd_wr_ctrl;
    localparam int DEPTH  = 16;
    localparam int LOW    = 2;
    localparam int HIGH   = 2;
    localparam int NOPC   = 64;
    localparam int PERIOD = 1 + LOW + HIGH;
`ifdef LCD_NOP_DELAY_EN
    localparam int GAP = NOPC;
`else
    localparam int GAP = 0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data  = 32'h0;
    logic        in_ready;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data;
    logic        busy;

    always #5 clk = ~clk;

    lcd_wr_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .WR_LOW_CYC (LOW),
        .WR_HIGH_CYC(HIGH),
        .NOP_CYC    (NOPC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .lcd_cs  (lcd_cs),
        .lcd_rs  (lcd_rs),
        .lcd_wr  (lcd_wr),
        .lcd_rd  (lcd_rd),
        .lcd_data(lcd_data),
        .busy    (busy)
    );

    typedef struct {
        logic        rs;
        logic [15:0] data;
        int          lo_len;
        bit          cs_ok;
        int          cyc;
        int          cs_hi;
    } obs_t;

    obs_t obs_mem [0:511];
    int   obs_wr   = 0;
    int   obs_rd   = 0;
    int   cyc      = 0;
    int   cs_hi    = 0;
    int   cs_falls = 0;
    int   cs_rises = 0;
    int   lo_len   = 0;
    bit   lo_cs_ok = 1'b1;
    logic prev_wr  = 1'b1;
    logic prev_cs  = 1'b1;

    int   errors = 0;
    int   checks = 0;
    logic [16:0] exp_q [$];

    // Bus monitor: one record per completed strobe (rising edge of lcd_wr).
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_cs <= lcd_cs;
        prev_wr <= lcd_wr;
        if (lcd_cs) cs_hi <= cs_hi + 1;
        if (prev_cs && !lcd_cs) cs_falls <= cs_falls + 1;
        if (!prev_cs && lcd_cs) cs_rises <= cs_rises + 1;
        if (reset) begin
            lo_len   <= 0;
            lo_cs_ok <= 1'b1;
        end else if (!lcd_wr) begin
            lo_len   <= lo_len + 1;
            lo_cs_ok <= lo_cs_ok && !lcd_cs;
        end else if (!prev_wr) begin
            if (obs_wr < 512)
                obs_mem[obs_wr] <= '{rs: lcd_rs, data: lcd_data, lo_len: lo_len,
                                     cs_ok: lo_cs_ok && !lcd_cs, cyc: cyc, cs_hi: cs_hi};
            obs_wr   <= obs_wr + 1;
            lo_len   <= 0;
            lo_cs_ok <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_write(input logic [31:0] w);
        return w[31] && (w[17:16] == 2'b01 || w[17:16] == 2'b10);
    endfunction

    task automatic send_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        if (is_write(w)) exp_q.push_back({w[17], w[15:0]});
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain"}, busy, 0);
        idle(3);
    endtask

    task automatic check_strobes(input string tag, input bit need_empty);
        logic [16:0] e;
        while (obs_rd < obs_wr && obs_rd < 512) begin
            chk({tag, "_unexpected"}, exp_q.size() != 0, 1);
            e = 17'h0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            chk({tag, "_word"}, {obs_mem[obs_rd].rs, obs_mem[obs_rd].data}, e);
            chk({tag, "_lowlen"}, obs_mem[obs_rd].lo_len, LOW);
            chk({tag, "_cslow"}, obs_mem[obs_rd].cs_ok, 1);
            obs_rd++;
        end
        if (need_empty) chk({tag, "_missing"}, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  cs_v, wr_v, ecs, ewr;
        logic        rs_s;
        logic [15:0] d_s;
        logic [31:0] w;
        logic [31:0] rw [0:6];
        int base, c0, r0, f0;

        // Reset and idle pin state
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("rst_cs", lcd_cs, 1);
        chk("rst_wr", lcd_wr, 1);
        chk("rst_rs", lcd_rs, 1);
        chk("rst_data", lcd_data, 0);
        chk("rst_rd", lcd_rd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);

        // Single command: cs falls two edges after acceptance, wr low for LOW cycles
        send_word(32'h80012a00);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            cs_v[k] = lcd_cs;
            wr_v[k] = lcd_wr;
            if (k == 2) begin
                rs_s = lcd_rs;
                d_s  = lcd_data;
            end
            ecs[k] = !(k >= 2 && k < 2 + PERIOD);
            ewr[k] = !(k >= 3 && k < 3 + LOW);
        end
        chk("single_cs_trace", cs_v, ecs);
        chk("single_wr_trace", wr_v, ewr);
        chk("single_rs", rs_s, 0);
        chk("single_data", d_s, 16'h2a00);
        #1;
        wait_drain("single");
        check_strobes("single", 1);

        // Stream of 20 data words with in_valid held
        base = obs_wr;
        c0   = cyc;
        r0   = cs_rises;
        for (int i = 0; i < 20; i++) send_word(32'h8002f800);
        chk("stream_nostall", cyc - c0, 20);
        chk("stream_full_ready", in_ready, 0);
        wait_drain("stream");
        chk("stream_count", obs_wr - base, 20);
        chk("stream_span", obs_mem[base + 19].cyc - obs_mem[base].cyc, 19 * PERIOD);
        chk("stream_cs_rises", cs_rises - r0, 1);
        check_strobes("stream", 1);

        // Push and pop on the same edge at count 15 (two skipped pushes line the pop up)
        send_word(32'h80020001);
        idle(2);
        for (int i = 0; i < 20; i++) begin
            send_word(32'h80020000 | (i + 2));
            if (i == 18) chk("pushpop15_ready", in_ready, 1);
            if (i == 19) chk("after_push16_ready", in_ready, 0);
        end
        wait_drain("pushpop");
        check_strobes("pushpop", 1);

        // Zero word between two commands
        base = obs_wr;
        send_word(32'h80011111);
        send_word(32'h00000000);
        send_word(32'h80012222);
        wait_drain("nop");
        chk("nop_count", obs_wr - base, 2);
        chk("nop_gap_cs_hi", obs_mem[base + 1].cs_hi - obs_mem[base].cs_hi, GAP);
        chk("nop_gap_cyc", obs_mem[base + 1].cyc - obs_mem[base].cyc, PERIOD + GAP);
        check_strobes("nop", 1);

        // Invalid words are swallowed without bus activity
        base = obs_wr;
        f0   = cs_falls;
        send_word(32'h00030000);
        chk("inv1_busy", busy, 0);
        send_word(32'h7fff1234);
        chk("inv2_busy", busy, 0);
        idle(10);
        chk("inv_cs_falls", cs_falls - f0, 0);
        chk("inv_strobes", obs_wr - base, 0);
        chk("inv_busy_end", busy, 0);

        // Reset in the first STROBE_LO cycle of the second word
        base = obs_wr;
        for (int i = 0; i < 7; i++) begin
            rw[i] = (i % 2 == 1) ? (32'h80020000 | (i * 16'h1111)) : (32'h80010000 | (i * 16'h0101 + 16'h0a00));
            send_word(rw[i]);
        end
        idle(1);
        w = rw[1];
        chk("rstmid_pre_cs", lcd_cs, 0);
        chk("rstmid_pre_data", lcd_data, w[15:0]);
        reset = 1'b1;
        idle(1);
        chk("rstmid_wr", lcd_wr, 1);
        chk("rstmid_cs", lcd_cs, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", in_ready, 1);
        f0    = cs_falls;
        reset = 1'b0;
        idle(40);
        chk("rstmid_strobes", obs_wr - base, 1);
        chk("rstmid_cs_falls", cs_falls - f0, 0);
        chk("rstmid_busy_end", busy, 0);
        check_strobes("rstmid", 0);
        exp_q.delete();

        // Randomized mix of writes, junk words and delays with random gaps
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 9: begin
                    w[31]    = 1'b1;
                    w[17:16] = 2'($urandom_range(1, 2));
                end
                4, 5: begin
                    w[31]    = 1'b1;
                    w[17:16] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                end
                6, 7: begin
                    w[31] = 1'b0;
                    w[0]  = 1'b1;
                end
                default: w = 32'h0;
            endcase
            send_word(w);
            idle($urandom_range(0, 2));
        end
        wait_drain("rand");
        check_strobes("rand", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
